alu_mdu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle ALU control path. It decodes `aluop`/`funct` and executes the operation in one of two ways:
- single-cycle logic/arithmetic ops complete in one cycle with a registered result;
- multiply/divide ops iterate over `WIDTH` cycles and write the `hi`/`lo` registers.

It sits in the EX stage and uses a start/busy/done handshake, so the control unit stalls issue while `busy` is high.

---
 rtl/alu_mdu.sv | 187 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with an iterative multiply/divide unit.
// Single-cycle ops register result/zero in one edge. mult/div run one
// shift-add or restoring shift-subtract step per cycle for WIDTH cycles.
// A final FIX cycle then applies the sign correction and writes hi/lo.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  typedef enum logic [2:0] {K_ALU, K_MULT, K_MULTU, K_DIV, K_DIVU, K_BAD} kind_t;

  state_t             state;
  kind_t              kind;
  logic [WIDTH-1:0]   alu_res;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  // Shared datapath: mult uses acc_hi:acc_lo as the product/multiplier
  // shift register; div uses acc_hi as the remainder and acc_lo as the
  // dividend/quotient shift register. opnd holds multiplicand or divisor.
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic               is_div_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  // Decode aluop/funct into an operation class and the single-cycle result.
  always_comb begin
    kind    = K_BAD;
    alu_res = '0;
    case (aluop)
      2'b00: begin kind = K_ALU; alu_res = a + b; end
      2'b01: begin kind = K_ALU; alu_res = a - b; end
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: begin kind = K_ALU; alu_res = a + b; end
          6'b100010, 6'b100011: begin kind = K_ALU; alu_res = a - b; end
          6'b100100: begin kind = K_ALU; alu_res = a & b; end
          6'b100101: begin kind = K_ALU; alu_res = a | b; end
          6'b100110: begin kind = K_ALU; alu_res = a ^ b; end
          6'b100111: begin kind = K_ALU; alu_res = ~(a | b); end
          6'b101010: begin kind = K_ALU; alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)}; end
          6'b101011: begin kind = K_ALU; alu_res = {{(WIDTH-1){1'b0}}, a < b}; end
          6'b010000: begin kind = K_ALU; alu_res = hi; end
          6'b010010: begin kind = K_ALU; alu_res = lo; end
          6'b011000: kind = K_MULT;
          6'b011001: kind = K_MULTU;
          6'b011010: kind = K_DIV;
          6'b011011: kind = K_DIVU;
          default:   kind = K_BAD;
        endcase
      end
      default: kind = K_BAD;
    endcase
  end

  // Operand magnitudes for the signed ops; unsigned ops pass through.
  assign signed_op = (kind == K_MULT) || (kind == K_DIV);
  assign is_div_op = (kind == K_DIV) || (kind == K_DIVU);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One multiply step: conditionally add the multiplicand, then shift right.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  // One restoring divide step: shift in the next dividend bit, trial-subtract.
  // When the subtraction succeeds the difference is below 2^WIDTH, so the
  // low WIDTH bits of the shifted remainder are enough to form it.
  assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
  assign ge       = shifted >= {1'b0, opnd};
  assign diff     = shifted[WIDTH-1:0] - opnd;
  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = -prod;

  // Control FSM with registered outputs and the iterative datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (kind)
              K_ALU: begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                done   <= 1'b1;
              end
              K_BAD: begin
                result  <= '0;
                zero    <= 1'b1;
                done    <= 1'b1;
                illegal <= 1'b1;
              end
              default: begin
                is_div <= is_div_op;
                acc_hi <= '0;
                if (is_div_op) begin
                  acc_lo <= a_mag;
                  opnd   <= b_mag;
                  // A zero divisor keeps the all-ones quotient unsigned.
                  neg_q  <= (a_neg ^ b_neg) & (b != '0);
                  neg_r  <= a_neg;
                end else begin
                  acc_lo <= b_mag;
                  opnd   <= a_mag;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= 1'b0;
                end
                cnt   <= CW'(WIDTH);
                busy  <= 1'b1;
                state <= ITER;
              end
            endcase
          end
        end
        ITER: begin
          if (is_div) begin
            acc_hi <= ge ? diff : shifted[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_q ? -acc_lo : acc_lo;
            hi <= neg_r ? -acc_hi : acc_hi;
          end else begin
            {hi, lo} <= neg_q ? prod_neg : prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed table, hand sequences for multi-cycle corners and
// randomized ops checked against an arithmetic reference model.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   aluop = 2'b00;
  logic [5:0]   funct = 6'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, illegal;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [W-1:0] m_result = '0;
  logic         m_zero = 1'b1;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_ill = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  logic [5:0]  fl[16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                          6'b100100, 6'b100101, 6'b100110, 6'b100111,
                          6'b101010, 6'b101011, 6'b010000, 6'b010010,
                          6'b011000, 6'b011001, 6'b011010, 6'b011011};
  logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model computed directly from the operation definitions.
  task automatic model_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y, output bit multi);
    longint      sx, sy, q, r;
    logic [63:0] p;
    bit          single;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    multi  = 0;
    single = 1;
    m_ill  = 0;
    if (op == 2'b00) m_result = x + y;
    else if (op == 2'b01) m_result = x - y;
    else if (op == 2'b11) begin m_result = 0; m_ill = 1; end
    else begin
      case (f)
        6'b100000, 6'b100001: m_result = x + y;
        6'b100010, 6'b100011: m_result = x - y;
        6'b100100: m_result = x & y;
        6'b100101: m_result = x | y;
        6'b100110: m_result = x ^ y;
        6'b100111: m_result = ~(x | y);
        6'b101010: m_result = (sx < sy) ? 32'd1 : 32'd0;
        6'b101011: m_result = (x < y) ? 32'd1 : 32'd0;
        6'b010000: m_result = m_hi;
        6'b010010: m_result = m_lo;
        6'b011000: begin single = 0; p = sx * sy; {m_hi, m_lo} = p; end
        6'b011001: begin single = 0; p = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = p; end
        6'b011010, 6'b011011: begin
          single = 0;
          if (y == 0) begin m_lo = 32'hFFFFFFFF; m_hi = x; end
          else if (f == 6'b011010) begin
            q = sx / sy; r = sx % sy;
            m_lo = q[31:0]; m_hi = r[31:0];
          end else begin
            m_lo = x / y; m_hi = x % y;
          end
        end
        default: begin m_result = 0; m_ill = 1; end
      endcase
    end
    multi = !single;
    if (single) m_zero = (m_result == 0);
  endtask

  // Issue one op from a point 1ns after an edge; return edges after the
  // accepting edge until done is seen, and the number of busy samples.
  task automatic apply(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bc);
    aluop = op; funct = f; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; funct = 6'($urandom);
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
    if (lat >= 100) chk("timeout_waiting_done", 64'(lat), 64'd0);
    $display("txn op=%b funct=%b a=%h b=%h -> result=%h zero=%b hi=%h lo=%h illegal=%b edges=%0d",
             op, f, x, y, result, zero, hi, lo, illegal, lat);
  endtask

  initial begin
    int lat, bc, dones, done_at;
    bit multi;
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] x, y;

    vecs[0]  = '{2'b00, 6'h00,        32'd7,        32'd5,        32'd12,       32'h0,        32'h0,        1'b0, 0};
    vecs[1]  = '{2'b01, 6'h00,        32'd5,        32'd5,        32'd0,        32'h0,        32'h0,        1'b0, 0};
    vecs[2]  = '{2'b10, 6'b101010,    32'hFFFFFFFF, 32'd1,        32'd1,        32'h0,        32'h0,        1'b0, 0};
    vecs[3]  = '{2'b10, 6'b101011,    32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        32'h0,        1'b0, 0};
    vecs[4]  = '{2'b10, 6'b100100,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        32'h0,        1'b0, 0};
    vecs[5]  = '{2'b10, 6'b100111,    32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 0};
    vecs[6]  = '{2'b10, 6'b011000,    32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[7]  = '{2'b10, 6'b011001,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 33};
    vecs[8]  = '{2'b10, 6'b011010,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{2'b10, 6'b011010,    32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33};
    vecs[10] = '{2'b10, 6'b011011,    32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        32'hFFFFFFFF, 1'b0, 33};
    vecs[11] = '{2'b10, 6'b010000,    32'd0,        32'd0,        32'd9,        32'd9,        32'hFFFFFFFF, 1'b0, 0};
    vecs[12] = '{2'b10, 6'b010010,    32'd0,        32'd0,        32'hFFFFFFFF, 32'd9,        32'hFFFFFFFF, 1'b0, 0};
    vecs[13] = '{2'b10, 6'b111111,    32'd3,        32'd4,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b1, 0};
    vecs[14] = '{2'b00, 6'h00,        32'hFFFFFFFF, 32'd1,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b0, 0};
    vecs[15] = '{2'b11, 6'b100000,    32'd3,        32'd4,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b1, 0};
    vecs[16] = '{2'b10, 6'b100101,    32'h0F,       32'hF0,       32'hFF,       32'd9,        32'hFFFFFFFF, 1'b0, 0};
    vecs[17] = '{2'b10, 6'b011010,    32'hFFFFFFF0, 32'd0,        32'hFF,       32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 33};
    vecs[18] = '{2'b10, 6'b100011,    32'd0,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 0};
    vecs[19] = '{2'b10, 6'b011001,    32'd65536,    32'd65536,    32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 33};

    // Reset values
    #12;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      model_op(vecs[i].op, vecs[i].f, vecs[i].x, vecs[i].y, multi);
      apply(vecs[i].op, vecs[i].f, vecs[i].x, vecs[i].y, lat, bc);
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(vecs[i].res == 32'd0));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
      chk($sformatf("vec%0d_illegal", i), 64'(illegal), 64'(vecs[i].ill));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].lat));
      if (i % 3 == 0) begin
        @(posedge clk); #1;
        chk($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
        chk($sformatf("vec%0d_illegal_one_cycle", i), 64'(illegal), 64'd0);
      end
    end

    // Start while busy is ignored: mult 123 * -5, add requested mid-flight
    model_op(2'b10, 6'b011000, 32'd123, 32'hFFFFFFFB, multi);
    aluop = 2'b10; funct = 6'b011000; a = 32'd123; b = 32'hFFFFFFFB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin aluop = 2'b00; funct = 6'h00; a = 32'd1; b = 32'd1; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin dones++; done_at = c; end
    end
    $display("txn busy-start mult 123*-5 -> hi=%h lo=%h result=%h dones=%0d", hi, lo, result, dones);
    chk("busy_start_done_count", 64'(dones), 64'd1);
    chk("busy_start_done_edge", 64'(done_at), 64'd33);
    chk("busy_start_hi", 64'(hi), 64'hFFFFFFFF);
    chk("busy_start_lo", 64'(lo), 64'hFFFFFD99);
    chk("busy_start_result_held", 64'(result), 64'hFFFFFFFF);

    // Asynchronous reset in the middle of a divide
    aluop = 2'b10; funct = 6'b011010; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin @(posedge clk); #1; end
    chk("midrst_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn reset during div -> busy=%b hi=%h lo=%h result=%h", busy, hi, lo, result);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_result = '0; m_zero = 1'b1; m_hi = '0; m_lo = '0;
    model_op(2'b10, 6'b011000, 32'd6, 32'hFFFFFFF9, multi);
    apply(2'b10, 6'b011000, 32'd6, 32'hFFFFFFF9, lat, bc);
    chk("postrst_mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("postrst_mult_lo", 64'(lo), 64'hFFFFFFD6);
    chk("postrst_mult_latency", 64'(lat), 64'd33);

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin op = 2'b00; f = 6'($urandom); end
      else if (sel == 1) begin op = 2'b01; f = 6'($urandom); end
      else if (sel == 2) begin op = 2'b11; f = 6'($urandom); end
      else if (sel == 3) begin op = 2'b10; f = 6'b111110; end
      else begin op = 2'b10; f = fl[$urandom_range(0, 15)]; end
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      model_op(op, f, x, y, multi);
      apply(op, f, x, y, lat, bc);
      chk($sformatf("rnd%0d_result", n), 64'(result), 64'(m_result));
      chk($sformatf("rnd%0d_zero", n), 64'(zero), 64'(m_zero));
      chk($sformatf("rnd%0d_hi", n), 64'(hi), 64'(m_hi));
      chk($sformatf("rnd%0d_lo", n), 64'(lo), 64'(m_lo));
      chk($sformatf("rnd%0d_illegal", n), 64'(illegal), 64'(m_ill));
      chk($sformatf("rnd%0d_latency", n), 64'(lat), multi ? 64'(W + 1) : 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
